fpu_cmd_seq: RTL and testbench

FPU_CMD_SEQ -- requirements
Module: fpu_cmd_seq

---
 rtl/fpu_cmd_seq.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_fpu_cmd_seq.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_cmd_seq
//  Description : Command sequencer in front of a register-file FPU. Commands
//                are queued in a small FIFO, then issued one at a time as a
//                WRITE or a LOAD/LOAD/EXEC operation. Each command ends in a
//                single response carrying the result, the flags and an error
//                code.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_cmd_seq #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  // command side
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [4:0]  cmd_a,
  input  logic [4:0]  cmd_b,
  input  logic [4:0]  cmd_d,
  input  logic [31:0] cmd_data,
  // FPU control side
  output logic [2:0]  fpu_opcode,
  output logic [4:0]  fpu_addr1,
  output logic [4:0]  fpu_addr2,
  output logic [4:0]  fpu_addr3,
  output logic        fpu_enable,
  output logic        fpu_ld,
  output logic        fpu_act,
  output logic [31:0] fpu_inp,
  input  logic [31:0] fpu_out,
  input  logic        fpu_done,
  input  logic [7:0]  fpu_flags,
  // response side
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [7:0]  rsp_flags,
  output logic [1:0]  rsp_err
);

  localparam int         c_aw            = $clog2(DEPTH);
  localparam int         c_cw            = c_aw + 1;
  localparam int         c_tw            = $clog2(TIMEOUT + 1);
  localparam logic [2:0] c_op_write      = 3'd7;
  localparam logic [2:0] c_op_bad5       = 3'd5;
  localparam logic [2:0] c_op_bad6       = 3'd6;
  localparam logic [1:0] c_err_ok        = 2'd0;
  localparam logic [1:0] c_err_timeout   = 2'd1;
  localparam logic [1:0] c_err_illegal   = 2'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    LOAD0 = 3'd2,
    LOAD1 = 3'd3,
    EXEC  = 3'd4,
    RESP  = 3'd5
  } state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [4:0]  d;
    logic [31:0] data;
  } cmd_t;

  // FIFO storage has no reset: only entries between the pointers are ever read
  cmd_t               mem_q [DEPTH];

  state_t             state_q,      state_d;
  logic [c_aw-1:0]    wr_ptr_q,     wr_ptr_d;
  logic [c_aw-1:0]    rd_ptr_q,     rd_ptr_d;
  logic [c_cw-1:0]    count_q,      count_d;
  logic               rdy_en_q,     rdy_en_d;
  cmd_t               cur_q,        cur_d;
  logic [c_tw-1:0]    cnt_q,        cnt_d;
  logic               rsp_valid_q,  rsp_valid_d;
  logic [31:0]        rsp_data_q,   rsp_data_d;
  logic [7:0]         rsp_flags_q,  rsp_flags_d;
  logic [1:0]         rsp_err_q,    rsp_err_d;
  logic [2:0]         fpu_opcode_q, fpu_opcode_d;
  logic [4:0]         fpu_addr1_q,  fpu_addr1_d;
  logic [4:0]         fpu_addr2_q,  fpu_addr2_d;
  logic [4:0]         fpu_addr3_q,  fpu_addr3_d;
  logic               fpu_enable_q, fpu_enable_d;
  logic               fpu_ld_q,     fpu_ld_d;
  logic               fpu_act_q,    fpu_act_d;
  logic [31:0]        fpu_inp_q,    fpu_inp_d;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  cmd_t               w_in;
  cmd_t               w_head;

  assign w_full    = (count_q == c_cw'(DEPTH));
  assign w_empty   = (count_q == '0);
  // rdy_en_q holds ready low through reset and for the clock of release
  assign cmd_ready = rdy_en_q & ~w_full;
  assign w_push    = cmd_valid & cmd_ready;
  // only IDLE takes a new command, which keeps one command in flight
  assign w_pop     = (state_q == IDLE) & ~w_empty;
  assign w_in      = '{op: cmd_op, a: cmd_a, b: cmd_b, d: cmd_d, data: cmd_data};
  assign w_head    = mem_q[rd_ptr_q];

  // Write the incoming command into the FIFO slot at the write pointer
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= w_in;
    end
  end

  // Next-state: FIFO bookkeeping, sequencing FSM, response and FPU controls
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    rdy_en_d     = 1'b1;
    cur_d        = cur_q;
    cnt_d        = cnt_q;
    rsp_data_d   = rsp_data_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;

    if (w_push) begin
      wr_ptr_d = wr_ptr_q + c_aw'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + c_aw'(1);
    end
    unique case ({w_push, w_pop})
      2'b10:   count_d = count_q + c_cw'(1);
      2'b01:   count_d = count_q - c_cw'(1);
      default: count_d = count_q;
    endcase

    unique case (state_q)
      IDLE: begin
        if (w_pop) begin
          cur_d = w_head;
          if (w_head.op == c_op_write) begin
            state_d = WRITE;
          end else if ((w_head.op == c_op_bad5) || (w_head.op == c_op_bad6)) begin
            // illegal opcodes never reach the FPU
            state_d     = RESP;
            rsp_data_d  = '0;
            rsp_flags_d = '0;
            rsp_err_d   = c_err_illegal;
          end else begin
            state_d = LOAD0;
          end
        end
      end
      WRITE: begin
        state_d     = RESP;
        rsp_data_d  = cur_q.data;
        rsp_flags_d = '0;
        rsp_err_d   = c_err_ok;
      end
      LOAD0: begin
        state_d = LOAD1;
      end
      LOAD1: begin
        state_d = EXEC;
        cnt_d   = '0;
      end
      EXEC: begin
        cnt_d = cnt_q + c_tw'(1);
        // done wins over a timeout that expires in the same cycle
        if (fpu_done) begin
          state_d     = RESP;
          rsp_data_d  = fpu_out;
          rsp_flags_d = fpu_flags;
          rsp_err_d   = c_err_ok;
        end else if (cnt_q == c_tw'(TIMEOUT - 1)) begin
          state_d     = RESP;
          rsp_data_d  = '0;
          rsp_flags_d = '0;
          rsp_err_d   = c_err_timeout;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rsp_valid_d = (state_d == RESP);

    // FPU controls are registered from the next state so they line up with it;
    // addresses, opcode and write data hold whenever not being driven
    fpu_enable_d = 1'b1;
    fpu_ld_d     = 1'b1;
    fpu_act_d    = 1'b0;
    fpu_opcode_d = fpu_opcode_q;
    fpu_addr1_d  = fpu_addr1_q;
    fpu_addr2_d  = fpu_addr2_q;
    fpu_addr3_d  = fpu_addr3_q;
    fpu_inp_d    = fpu_inp_q;
    unique case (state_d)
      WRITE: begin
        fpu_enable_d = 1'b0;
        fpu_addr1_d  = cur_d.d;
        fpu_inp_d    = cur_d.data;
      end
      LOAD0, LOAD1: begin
        fpu_addr1_d  = cur_d.a;
        fpu_addr2_d  = cur_d.b;
        fpu_opcode_d = cur_d.op;
      end
      EXEC: begin
        fpu_ld_d     = 1'b0;
        fpu_act_d    = 1'b1;
        fpu_addr1_d  = cur_d.a;
        fpu_addr2_d  = cur_d.b;
        fpu_addr3_d  = cur_d.d;
        fpu_opcode_d = cur_d.op;
      end
      default: begin
      end
    endcase
  end

  // State registers; reset drops queued and in-flight work without a response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rdy_en_q     <= 1'b0;
      cur_q        <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= '0;
      fpu_opcode_q <= '0;
      fpu_addr1_q  <= '0;
      fpu_addr2_q  <= '0;
      fpu_addr3_q  <= '0;
      fpu_enable_q <= 1'b1;
      fpu_ld_q     <= 1'b1;
      fpu_act_q    <= 1'b0;
      fpu_inp_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rdy_en_q     <= rdy_en_d;
      cur_q        <= cur_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
      fpu_opcode_q <= fpu_opcode_d;
      fpu_addr1_q  <= fpu_addr1_d;
      fpu_addr2_q  <= fpu_addr2_d;
      fpu_addr3_q  <= fpu_addr3_d;
      fpu_enable_q <= fpu_enable_d;
      fpu_ld_q     <= fpu_ld_d;
      fpu_act_q    <= fpu_act_d;
      fpu_inp_q    <= fpu_inp_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;
  assign fpu_opcode = fpu_opcode_q;
  assign fpu_addr1  = fpu_addr1_q;
  assign fpu_addr2  = fpu_addr2_q;
  assign fpu_addr3  = fpu_addr3_q;
  assign fpu_enable = fpu_enable_q;
  assign fpu_ld     = fpu_ld_q;
  assign fpu_act    = fpu_act_q;
  assign fpu_inp    = fpu_inp_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_cmd_seq
//  Description : Directed self-checking bench for fpu_cmd_seq with a small
//                FPU model and a response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fpu_cmd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [4:0]  cmd_a = '0;
  logic [4:0]  cmd_b = '0;
  logic [4:0]  cmd_d = '0;
  logic [31:0] cmd_data = '0;
  logic [2:0]  fpu_opcode;
  logic [4:0]  fpu_addr1;
  logic [4:0]  fpu_addr2;
  logic [4:0]  fpu_addr3;
  logic        fpu_enable;
  logic        fpu_ld;
  logic        fpu_act;
  logic [31:0] fpu_inp;
  logic [31:0] fpu_out = '0;
  logic        fpu_done = 1'b0;
  logic [7:0]  fpu_flags = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [7:0]  rsp_flags;
  logic [1:0]  rsp_err;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  flags;
    logic [1:0]  err;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int          n_rsp = 0;

  // FPU model state
  int          exec_n = 0;
  int          last_exec = 0;
  int          done_at = 0;
  bit          act_seen = 1'b0;
  logic [31:0] model_out = '0;
  logic [7:0]  model_flags = '0;
  logic [31:0] regs [32];

  always #5 clk = ~clk;

  fpu_cmd_seq #(.DEPTH(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_d(cmd_d), .cmd_data(cmd_data),
    .fpu_opcode(fpu_opcode), .fpu_addr1(fpu_addr1), .fpu_addr2(fpu_addr2),
    .fpu_addr3(fpu_addr3), .fpu_enable(fpu_enable), .fpu_ld(fpu_ld),
    .fpu_act(fpu_act), .fpu_inp(fpu_inp), .fpu_out(fpu_out),
    .fpu_done(fpu_done), .fpu_flags(fpu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic [31:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_d     = d;
    cmd_data  = data;
  endtask

  // Wait for the transfer, record the expected response, drop valid
  task automatic wait_accept();
    int   n = 0;
    exp_t e;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    check("accept_bound", 32'(n < 200), 32'd1);
    if (cmd_op == 3'd7) begin
      e.data = cmd_data; e.flags = 8'h00; e.err = 2'd0;
    end else if (cmd_op == 3'd5 || cmd_op == 3'd6) begin
      e.data = '0; e.flags = 8'h00; e.err = 2'd2;
    end else if (done_at != 0 && done_at <= 15) begin
      e.data = model_out; e.flags = model_flags; e.err = 2'd0;
    end else begin
      e.data = '0; e.flags = 8'h00; e.err = 2'd1;
    end
    sb.push_back(e);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] d, input logic [31:0] data);
    drive(op, a, b, d, data);
    wait_accept();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    check("idle_bound", 32'(n < 500), 32'd1);
  endtask

  task automatic wait_rsp_valid();
    int n = 0;
    while (!rsp_valid && n < 100) begin
      tick();
      n++;
    end
    check("rsp_valid_bound", 32'(n < 100), 32'd1);
  endtask

  // FPU model: counts EXEC cycles, raises done on the chosen cycle, stores writes
  always @(negedge clk) begin
    if (fpu_act) begin
      exec_n   = exec_n + 1;
      act_seen = 1'b1;
    end else begin
      if (exec_n != 0) last_exec = exec_n;
      exec_n = 0;
    end
    fpu_done  = fpu_act && (done_at != 0) && (exec_n == done_at);
    fpu_out   = model_out;
    fpu_flags = model_flags;
    if (!rst && !fpu_enable) regs[fpu_addr1] = fpu_inp;
  end

  // Scoreboard: every response handshake must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      check("rsp_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("rsp_data", rsp_data, mon_e.data);
        check("rsp_flags", 32'(rsp_flags), 32'(mon_e.flags));
        check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        n_rsp++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // ---------------- reset state ----------------
    #2 rst = 1'b1;
    tick();
    tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    check("rst_fpu_enable", 32'(fpu_enable), 32'd1);
    check("rst_fpu_ld", 32'(fpu_ld), 32'd1);
    check("rst_fpu_act", 32'(fpu_act), 32'd0);
    check("rst_fpu_opcode", 32'(fpu_opcode), 32'd0);
    check("rst_fpu_addr1", 32'(fpu_addr1), 32'd0);
    check("rst_fpu_inp", fpu_inp, 32'd0);
    rst = 1'b0;
    tick();
    check("rel_cmd_ready", 32'(cmd_ready), 32'd1);

    // ---------------- add then respond ----------------
    rsp_ready = 1'b1; done_at = 3; model_out = 32'h4040_0000; model_flags = 8'h00;
    drive(3'd7, 5'd0, 5'd0, 5'd1, 32'h3F80_0000);
    wait_accept();
    tick();
    check("wr_c1_rsp_valid", 32'(rsp_valid), 32'd0);
    check("wr_fpu_enable", 32'(fpu_enable), 32'd0);
    check("wr_fpu_addr1", 32'(fpu_addr1), 32'd1);
    check("wr_fpu_inp", fpu_inp, 32'h3F80_0000);
    tick();
    check("wr_c2_rsp_valid", 32'(rsp_valid), 32'd1);
    wait_idle();
    send(3'd7, 5'd0, 5'd0, 5'd2, 32'h4000_0000);
    wait_idle();
    check("model_reg1", regs[1], 32'h3F80_0000);
    check("model_reg2", regs[2], 32'h4000_0000);
    send(3'd0, 5'd1, 5'd2, 5'd3, 32'd0);
    tick();
    check("ld0_fpu_ld", 32'(fpu_ld), 32'd1);
    check("ld0_fpu_act", 32'(fpu_act), 32'd0);
    check("ld0_fpu_addr1", 32'(fpu_addr1), 32'd1);
    check("ld0_fpu_addr2", 32'(fpu_addr2), 32'd2);
    tick();
    tick();
    check("ex_fpu_act", 32'(fpu_act), 32'd1);
    check("ex_fpu_ld", 32'(fpu_ld), 32'd0);
    check("ex_fpu_addr3", 32'(fpu_addr3), 32'd3);
    tick();
    tick();
    check("op_lat_c5_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    check("op_lat_c6_rsp_valid", 32'(rsp_valid), 32'd1);
    wait_idle();
    check("add_exec_cycles", 32'(last_exec), 32'd3);
    check("add_rsp_count", 32'(n_rsp), 32'd3);

    // ---------------- timeout ----------------
    done_at = 0;
    send(3'd2, 5'd4, 5'd5, 5'd6, 32'd0);
    wait_idle();
    check("to_exec_cycles", 32'(last_exec), 32'd15);
    check("to_opcode_held", 32'(fpu_opcode), 32'd2);
    check("to_fpu_act_idle", 32'(fpu_act), 32'd0);

    // ---------------- illegal ops ----------------
    act_seen = 1'b0;
    send(3'd5, 5'd1, 5'd1, 5'd1, 32'd0);
    send(3'd6, 5'd1, 5'd1, 5'd1, 32'd0);
    wait_idle();
    check("ill_no_act", 32'(act_seen), 32'd0);
    check("ill_opcode_held", 32'(fpu_opcode), 32'd2);

    // ---------------- backpressure and full FIFO ----------------
    rsp_ready = 1'b0; done_at = 2; model_out = 32'h1111_2222; model_flags = 8'h05;
    send(3'd7, 5'd0, 5'd0, 5'd7, 32'hA000_0000);
    wait_rsp_valid();
    send(3'd1, 5'd1, 5'd2, 5'd8, 32'd0);
    send(3'd7, 5'd0, 5'd0, 5'd9, 32'hA000_0001);
    send(3'd4, 5'd3, 5'd4, 5'd10, 32'd0);
    send(3'd5, 5'd0, 5'd0, 5'd0, 32'd0);
    drive(3'd7, 5'd0, 5'd0, 5'd11, 32'hA000_0002);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_data", rsp_data, 32'hA000_0000);
    end
    rsp_ready = 1'b1;
    wait_accept();
    wait_idle();
    check("bp_rsp_count", 32'(n_rsp), 32'd12);

    // ---------------- push and pop together at DEPTH-1 ----------------
    rsp_ready = 1'b0;
    send(3'd7, 5'd0, 5'd0, 5'd1, 32'hB000_0000);
    wait_rsp_valid();
    send(3'd7, 5'd0, 5'd0, 5'd2, 32'hB000_0001);
    send(3'd7, 5'd0, 5'd0, 5'd3, 32'hB000_0002);
    send(3'd7, 5'd0, 5'd0, 5'd4, 32'hB000_0003);
    check("pp_count_before", 32'(dut.count_q), 32'd3);
    rsp_ready = 1'b1;
    tick();
    drive(3'd7, 5'd0, 5'd0, 5'd5, 32'hB000_0004);
    wait_accept();
    check("pp_count_after", 32'(dut.count_q), 32'd3);
    wait_idle();

    // ---------------- reset mid-EXEC ----------------
    done_at = 0;
    send(3'd0, 5'd1, 5'd2, 5'd12, 32'd0);
    send(3'd7, 5'd0, 5'd0, 5'd13, 32'hC000_0000);
    send(3'd7, 5'd0, 5'd0, 5'd14, 32'hC000_0001);
    n = 0;
    while (!fpu_act && n < 50) begin
      tick();
      n++;
    end
    check("mr_exec_bound", 32'(n < 50), 32'd1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mr_cmd_ready", 32'(cmd_ready), 32'd0);
    check("mr_fpu_act", 32'(fpu_act), 32'd0);
    check("mr_fpu_addr3", 32'(fpu_addr3), 32'd0);
    sb.delete();
    n = n_rsp;
    tick();
    rst = 1'b0;
    tick();
    check("mr_rel_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mr_fifo_empty", 32'(dut.count_q), 32'd0);
    for (int i = 0; i < 40; i++) tick();
    check("mr_no_stale_valid", 32'(rsp_valid), 32'd0);
    check("mr_no_stale_rsp", 32'(n_rsp), 32'(n));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
